// File: rtl/rmii_fcs_check.sv
// rtl/rmii_fcs_check.sv - RMII receive framer with CRC-32 residue check and per-frame status.
// Optional FCS stripping via `RMII_FCS_STRIP_EN (4-byte delay line withholds the FCS).
module rmii_fcs_check #(
    parameter int MAX_LEN = 1522,
    parameter int LEN_W   = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             crs_dv_i,
    input  logic [1:0]       rxd_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             sof_o,
    output logic             frame_done_o,
    output logic             fcs_ok_o,
    output logic             align_err_o,
    output logic             long_err_o,
    output logic [LEN_W-1:0] len_o
);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    state_t           r_state;
    logic             r_crs_dv_q;
    logic             r_seen01;
    logic             r_long;
    logic [31:0]      r_crc;
    logic [1:0]       r_phase;
    logic [5:0]       r_shift;
    logic [LEN_W-1:0] r_byte_cnt;

    logic [7:0]       w_byte;
    logic [31:0]      w_crc_next;
    logic [LEN_W-1:0] w_len;
    logic             w_len_ok;

    // Reflected CRC-32, wire order: rxd[0] then rxd[1].
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] n;
        n = c;
        for (int i = 0; i < 2; i++) begin
            if (n[0] ^ d[i])
                n = (n >> 1) ^ 32'hEDB8_8320;
            else
                n = n >> 1;
        end
        return n;
    endfunction

    assign w_byte     = {rxd_i, r_shift};
    assign w_crc_next = crc_step(r_crc, rxd_i);
    assign w_len_ok   = (r_byte_cnt >= LEN_W'(5));

`ifdef RMII_FCS_STRIP_EN
    logic [31:0] r_dl;
    assign w_len = (r_byte_cnt >= LEN_W'(4)) ? r_byte_cnt - LEN_W'(4) : '0;
`else
    assign w_len = r_byte_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_crs_dv_q   <= 1'b1;
            r_seen01     <= 1'b0;
            r_long       <= 1'b0;
            r_crc        <= CRC_INIT;
            r_phase      <= 2'd0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            sof_o        <= 1'b0;
            frame_done_o <= 1'b0;
            fcs_ok_o     <= 1'b0;
            align_err_o  <= 1'b0;
            long_err_o   <= 1'b0;
            len_o        <= '0;
`ifdef RMII_FCS_STRIP_EN
            r_dl         <= '0;
`endif
        end else begin
            r_crs_dv_q   <= crs_dv_i;
            valid_o      <= 1'b0;
            sof_o        <= 1'b0;
            frame_done_o <= 1'b0;
            fcs_ok_o     <= 1'b0;
            align_err_o  <= 1'b0;
            long_err_o   <= 1'b0;
            len_o        <= '0;
            case (r_state)
                S_IDLE: begin
                    if (crs_dv_i && !r_crs_dv_q) begin
                        r_state  <= S_PREAMBLE;
                        r_seen01 <= (rxd_i == 2'b01);
                        r_long   <= 1'b0;
                    end
                end
                S_PREAMBLE: begin
                    if (!crs_dv_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        case (rxd_i)
                            2'b00: ;
                            2'b01: r_seen01 <= 1'b1;
                            2'b11: begin
                                if (r_seen01) begin
                                    r_state    <= S_DATA;
                                    r_crc      <= CRC_INIT;
                                    r_phase    <= 2'd0;
                                    r_byte_cnt <= '0;
                                end else begin
                                    r_state <= S_DROP;
                                end
                            end
                            default: r_state <= S_DROP;
                        endcase
                    end
                end
                S_DATA: begin
                    if (!crs_dv_i) begin
                        r_state      <= S_IDLE;
                        frame_done_o <= 1'b1;
                        align_err_o  <= (r_phase != 2'd0);
                        fcs_ok_o     <= (r_crc == CRC_RESIDUE) && (r_phase == 2'd0) && w_len_ok;
                        len_o        <= w_len;
                    end else begin
                        r_crc   <= w_crc_next;
                        r_phase <= r_phase + 2'd1;
                        r_shift <= {rxd_i, r_shift[5:2]};
                        if (r_phase == 2'd3) begin
                            if (r_byte_cnt == LEN_W'(MAX_LEN)) begin
                                r_state    <= S_DROP;
                                r_long     <= 1'b1;
                                r_byte_cnt <= LEN_W'(MAX_LEN + 1);
                            end else begin
                                r_byte_cnt <= r_byte_cnt + LEN_W'(1);
`ifdef RMII_FCS_STRIP_EN
                                // A byte leaves only once four newer bytes exist behind it.
                                r_dl <= {r_dl[23:0], w_byte};
                                if (r_byte_cnt >= LEN_W'(4)) begin
                                    valid_o <= 1'b1;
                                    data_o  <= r_dl[31:24];
                                    sof_o   <= (r_byte_cnt == LEN_W'(4));
                                end
`else
                                valid_o <= 1'b1;
                                data_o  <= w_byte;
                                sof_o   <= (r_byte_cnt == '0);
`endif
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (!crs_dv_i) begin
                        r_state <= S_IDLE;
                        if (r_long) begin
                            frame_done_o <= 1'b1;
                            long_err_o   <= 1'b1;
                            len_o        <= w_len;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rmii_fcs_check.sv
// tb/tb_rmii_fcs_check.sv - directed self-checking bench for rmii_fcs_check.
module tb_rmii_fcs_check;
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 11;
`ifdef RMII_FCS_STRIP_EN
    localparam int GOOD_LEN   = 9;
    localparam int LONG_VALID = 60;
`else
    localparam int GOOD_LEN   = 13;
    localparam int LONG_VALID = 64;
`endif

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             crs_dv_i = 1'b0;
    logic [1:0]       rxd_i = 2'b00;
    logic [7:0]       data_o;
    logic             valid_o, sof_o, frame_done_o, fcs_ok_o, align_err_o, long_err_o;
    logic [LEN_W-1:0] len_o;

    rmii_fcs_check #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .crs_dv_i(crs_dv_i), .rxd_i(rxd_i),
        .data_o(data_o), .valid_o(valid_o), .sof_o(sof_o), .frame_done_o(frame_done_o),
        .fcs_ok_o(fcs_ok_o), .align_err_o(align_err_o), .long_err_o(long_err_o), .len_o(len_o)
    );

    always #10 clk = ~clk;

    logic [7:0] good [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                              8'h26, 8'h39, 8'hF4, 8'hCB};

    int errors = 0;
    int checks = 0;

    logic [7:0] cap[$];
    int         sof_idx[$];
    logic       d_fcs[$], d_align[$], d_long[$];
    int         d_len[$];
    int         stray = 0;
    int         cyc = 0;
    int         last_valid = -100;
    int         min_gap = 1000;

    always @(negedge clk) begin
        cyc++;
        if (valid_o) begin
            if (cyc - last_valid < min_gap) min_gap = cyc - last_valid;
            last_valid = cyc;
            if (sof_o) sof_idx.push_back(cap.size());
            cap.push_back(data_o);
        end else if (sof_o) begin
            stray++;
        end
        if (frame_done_o) begin
            d_fcs.push_back(fcs_ok_o);
            d_align.push_back(align_err_o);
            d_long.push_back(long_err_o);
            d_len.push_back(int'(len_o));
        end else if (fcs_ok_o || align_err_o || long_err_o || len_o != '0) begin
            stray++;
        end
    end

    task automatic drive(input logic dv, input logic [1:0] d);
        crs_dv_i = dv;
        rxd_i    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2]);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_good(input int flip_idx, input bit extra);
        logic [7:0] b;
        send_preamble();
        for (int i = 0; i < 13; i++) begin
            b = good[i];
            if (i == flip_idx) b = b ^ 8'h01;
            send_byte(b);
        end
        if (extra) drive(1'b1, 2'b01);
        drive(1'b0, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle(2);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (sof_o !== 1'b0) begin errors++; $display("FAIL reset_sof got=%b exp=0", sof_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done_o); end
        checks++; if (fcs_ok_o !== 1'b0) begin errors++; $display("FAIL reset_fcs got=%b exp=0", fcs_ok_o); end
        checks++; if (align_err_o !== 1'b0) begin errors++; $display("FAIL reset_align got=%b exp=0", align_err_o); end
        checks++; if (long_err_o !== 1'b0) begin errors++; $display("FAIL reset_long got=%b exp=0", long_err_o); end
        checks++; if (len_o !== '0) begin errors++; $display("FAIL reset_len got=%0d exp=0", len_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_o); end
        rst_i = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        int base, nd, ns;
        base = cap.size(); nd = d_fcs.size(); ns = sof_idx.size();
        send_good(-1, 1'b0);
        idle(3);
        checks++; if (cap.size() - base !== GOOD_LEN) begin errors++; $display("FAIL good_count got=%0d exp=%0d", cap.size() - base, GOOD_LEN); end
        for (int i = 0; i < GOOD_LEN; i++) begin
            if (base + i < cap.size()) begin
                checks++; if (cap[base+i] !== good[i]) begin errors++; $display("FAIL good_byte%0d got=%h exp=%h", i, cap[base+i], good[i]); end
            end
        end
        checks++; if (sof_idx.size() - ns !== 1) begin errors++; $display("FAIL good_sof_count got=%0d exp=1", sof_idx.size() - ns); end
        else begin
            checks++; if (sof_idx[ns] !== base) begin errors++; $display("FAIL good_sof_pos got=%0d exp=%0d", sof_idx[ns], base); end
        end
        checks++; if (d_fcs.size() - nd !== 1) begin errors++; $display("FAIL good_done_count got=%0d exp=1", d_fcs.size() - nd); end
        else begin
            checks++; if (d_fcs[nd] !== 1'b1) begin errors++; $display("FAIL good_fcs got=%b exp=1", d_fcs[nd]); end
            checks++; if (d_align[nd] !== 1'b0) begin errors++; $display("FAIL good_align got=%b exp=0", d_align[nd]); end
            checks++; if (d_long[nd] !== 1'b0) begin errors++; $display("FAIL good_long got=%b exp=0", d_long[nd]); end
            checks++; if (d_len[nd] !== GOOD_LEN) begin errors++; $display("FAIL good_len got=%0d exp=%0d", d_len[nd], GOOD_LEN); end
        end
    endtask

    task automatic test_bad_fcs();
        int base, nd;
        base = cap.size(); nd = d_fcs.size();
        send_good(2, 1'b0);
        idle(3);
        checks++; if (cap.size() - base !== GOOD_LEN) begin errors++; $display("FAIL badfcs_count got=%0d exp=%0d", cap.size() - base, GOOD_LEN); end
        checks++; if (d_fcs.size() - nd !== 1) begin errors++; $display("FAIL badfcs_done_count got=%0d exp=1", d_fcs.size() - nd); end
        else begin
            checks++; if (d_fcs[nd] !== 1'b0) begin errors++; $display("FAIL badfcs_fcs got=%b exp=0", d_fcs[nd]); end
            checks++; if (d_len[nd] !== GOOD_LEN) begin errors++; $display("FAIL badfcs_len got=%0d exp=%0d", d_len[nd], GOOD_LEN); end
        end
    endtask

    task automatic test_align();
        int nd;
        nd = d_fcs.size();
        send_good(-1, 1'b1);
        idle(3);
        checks++; if (d_fcs.size() - nd !== 1) begin errors++; $display("FAIL align_done_count got=%0d exp=1", d_fcs.size() - nd); end
        else begin
            checks++; if (d_align[nd] !== 1'b1) begin errors++; $display("FAIL align_flag got=%b exp=1", d_align[nd]); end
            checks++; if (d_fcs[nd] !== 1'b0) begin errors++; $display("FAIL align_fcs got=%b exp=0", d_fcs[nd]); end
        end
    endtask

    task automatic test_too_long();
        int base, nd;
        base = cap.size(); nd = d_fcs.size();
        send_preamble();
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        checks++; if (d_fcs.size() !== nd) begin errors++; $display("FAIL long_early_done got=%0d exp=%0d", d_fcs.size(), nd); end
        drive(1'b0, 2'b00);
        idle(3);
        checks++; if (cap.size() - base !== LONG_VALID) begin errors++; $display("FAIL long_count got=%0d exp=%0d", cap.size() - base, LONG_VALID); end
        else begin
            checks++; if (cap[cap.size()-1] !== 8'(LONG_VALID - 1)) begin errors++; $display("FAIL long_last got=%h exp=%h", cap[cap.size()-1], 8'(LONG_VALID - 1)); end
        end
        checks++; if (d_fcs.size() - nd !== 1) begin errors++; $display("FAIL long_done_count got=%0d exp=1", d_fcs.size() - nd); end
        else begin
            checks++; if (d_long[nd] !== 1'b1) begin errors++; $display("FAIL long_flag got=%b exp=1", d_long[nd]); end
            checks++; if (d_fcs[nd] !== 1'b0) begin errors++; $display("FAIL long_fcs got=%b exp=0", d_fcs[nd]); end
        end
    endtask

    task automatic test_bad_preamble();
        int base, nd;
        base = cap.size(); nd = d_fcs.size();
        for (int i = 0; i < 6; i++) send_byte(8'h55);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b10);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        send_byte(8'hD5);
        for (int i = 0; i < 13; i++) send_byte(good[i]);
        drive(1'b0, 2'b00);
        send_good(-1, 1'b0);
        idle(3);
        checks++; if (cap.size() - base !== GOOD_LEN) begin errors++; $display("FAIL badpre_count got=%0d exp=%0d", cap.size() - base, GOOD_LEN); end
        checks++; if (d_fcs.size() - nd !== 1) begin errors++; $display("FAIL badpre_done_count got=%0d exp=1", d_fcs.size() - nd); end
        else begin
            checks++; if (d_fcs[nd] !== 1'b1) begin errors++; $display("FAIL badpre_next_fcs got=%b exp=1", d_fcs[nd]); end
        end
    endtask

    task automatic test_back_to_back();
        int base, nd, ns;
        base = cap.size(); nd = d_fcs.size(); ns = sof_idx.size();
        send_good(-1, 1'b0);
        send_good(-1, 1'b0);
        idle(3);
        checks++; if (cap.size() - base !== 2 * GOOD_LEN) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", cap.size() - base, 2 * GOOD_LEN); end
        checks++; if (sof_idx.size() - ns !== 2) begin errors++; $display("FAIL b2b_sof_count got=%0d exp=2", sof_idx.size() - ns); end
        checks++; if (d_fcs.size() - nd !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", d_fcs.size() - nd); end
        else begin
            checks++; if (d_fcs[nd] !== 1'b1 || d_fcs[nd+1] !== 1'b1) begin errors++; $display("FAIL b2b_fcs got=%b%b exp=11", d_fcs[nd], d_fcs[nd+1]); end
        end
    endtask

    task automatic test_reset_mid();
        int base, nd;
        send_preamble();
        for (int i = 0; i < 4; i++) send_byte(good[i]);
        rst_i = 1'b1;
        drive(1'b1, good[4][1:0]);
        rst_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || frame_done_o !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got=%b%b exp=00", valid_o, frame_done_o); end
        base = cap.size(); nd = d_fcs.size();
        for (int i = 4; i < 13; i++) send_byte(good[i]);
        drive(1'b0, 2'b00);
        idle(2);
        checks++; if (cap.size() !== base) begin errors++; $display("FAIL rstmid_valid got=%0d exp=%0d", cap.size(), base); end
        checks++; if (d_fcs.size() !== nd) begin errors++; $display("FAIL rstmid_done got=%0d exp=%0d", d_fcs.size(), nd); end
        send_good(-1, 1'b0);
        idle(3);
        checks++; if (d_fcs.size() - nd !== 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", d_fcs.size() - nd); end
        else begin
            checks++; if (d_fcs[nd] !== 1'b1) begin errors++; $display("FAIL rstmid_next_fcs got=%b exp=1", d_fcs[nd]); end
            checks++; if (d_len[nd] !== GOOD_LEN) begin errors++; $display("FAIL rstmid_next_len got=%0d exp=%0d", d_len[nd], GOOD_LEN); end
        end
    endtask

    task automatic test_invariants();
        checks++; if (stray !== 0) begin errors++; $display("FAIL stray_status got=%0d exp=0", stray); end
        checks++; if (min_gap < 4) begin errors++; $display("FAIL valid_gap got=%0d exp>=4", min_gap); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_align();
        test_too_long();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
